vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates the raster scan that every sprite and background renderer consumes.
- Produces the pixel coordinates DrawX/DrawY, the active-video flag `blank`, and the sync pulses hs/vs.
- Also produces frame bookkeeping: a one-cycle `frame_start` pulse and an 8-bit `frame_count`.
- Sits between the pixel clock source and all renderers. Renderers index ROMs on DrawX/DrawY and register colour one clock later, so hs/vs carry a matching delay pipeline.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_DELAY, 1, enabled-pixel stages of delay on hs/vs relative to DrawX/DrawY; legal range 0..4

Ports:
- vga_clk  input  1  pixel-domain clock
- reset_n  input  1  asynchronous active-low reset
- pix_en  input  1  pixel advance enable; tie high when vga_clk is the pixel clock
- DrawX  output  10  current horizontal count, 0..H_TOTAL-1
- DrawY  output  10  current vertical count, 0..V_TOTAL-1
- blank  output  1  1 = active video (DrawX<H_VISIBLE and DrawY<V_VISIBLE); renderers drive colour only when high
- hs  output  1  horizontal sync, active low, delayed SYNC_DELAY enabled pixels
- vs  output  1  vertical sync, active low, delayed SYNC_DELAY enabled pixels
- frame_start  output  1  one-vga_clk pulse on entry to (0,0)
- frame_count  output  8  frames started since reset, wraps

Behaviour:
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525). Both totals must be ≤1024.
- Reset (reset_n low, asynchronous):
  - DrawX=H_TOTAL-1, DrawY=V_TOTAL-1.
  - blank=0, hs=1, vs=1, all delay stages=1.
  - frame_start=0, frame_count=0.
- Reset asserted mid-frame aborts the frame immediately. After release, the first enabled edge lands on (0,0).
- Counter advance, on each vga_clk rising edge with pix_en=1:
  - If DrawX<H_TOTAL-1: DrawX+1.
  - Else: DrawX←0 and DrawY advances.
  - DrawY advance: DrawY+1 if DrawY<V_TOTAL-1, else 0.
  - With pix_en=0, every register holds, except frame_start, which returns to 0.
- blank is registered together with the counters, so it always matches the DrawX/DrawY values presented in the same cycle.
- Raw sync, computed from the counters' next values:
  - hs_raw=0 iff H_VISIBLE+H_FP ≤ nextX < H_VISIBLE+H_FP+H_SYNC, i.e. 656..751.
  - vs_raw=0 iff V_VISIBLE+V_FP ≤ nextY < V_VISIBLE+V_FP+V_SYNC, i.e. 490..491.
  - vs is line-based; it switches together with the hs/DrawX wrap at the start of a line.
- Delay pipeline: hs_raw/vs_raw pass through SYNC_DELAY stages that shift only when pix_en=1.
  - SYNC_DELAY=0: hs/vs are registered alongside the counters, aligned with DrawX.
  - SYNC_DELAY=1: hs falls on the edge where DrawX goes 656→657.
- frame_start: registered 1 for exactly one vga_clk after the enabled edge that loads (0,0), including the first edge after reset. It is 0 at all other times, even if pix_en stays low afterwards.
- frame_count increments by 1 on the same edge that loads (0,0), and wraps 255→0.
- No combinational path from pix_en to any output.

Test Plan:
- Reset release, pix_en=1, SYNC_DELAY=1 → first edge gives DrawX=0, DrawY=0, blank=1, frame_start=1 for one cycle, frame_count=1.
- Run one line → blank=1 for DrawX 0..639 and 0 for 640..799. hs=0 for exactly 96 consecutive cycles, beginning one cycle after DrawX=656 appears. DrawX wraps 799→0 with DrawY 0→1.
- Run full frame → vs=0 for exactly 2×800 enabled cycles covering lines 490–491, delayed by 1 pixel. frame_start pulses again after exactly 420000 enabled cycles. frame_count=2.
- pix_en toggling 1,0,1,0 (50% duty) → counters advance every other clock. Line length is 1600 vga_clk. frame_start stays one vga_clk wide. Sync widths are 192 clocks.
- Assert reset_n low at DrawX=300, DrawY=200 (asynchronous, between edges) → outputs go immediately to the reset values listed in Behaviour. After release, the next enabled edge gives (0,0) with frame_count=1.
- Run 256 frames (SYNC_DELAY=0 build) → frame_count wraps 255→0. hs falls in the same cycle DrawX=656 is presented.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, active-video flag, delayed
// active-low syncs and frame bookkeeping, all advancing only on pix_en.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0]          x_q, x_d, y_q, y_d;
  logic [9:0]          x_nxt, y_nxt;
  logic                blank_q, blank_d;
  logic                fs_q, fs_d;
  logic [7:0]          fc_q, fc_d;
  logic                hs_raw, vs_raw;
  // Stage 0 is aligned with the counters; stage SYNC_DELAY drives the pins.
  logic [SYNC_DELAY:0] hs_pipe_q, hs_pipe_d;
  logic [SYNC_DELAY:0] vs_pipe_q, vs_pipe_d;

  always_comb begin
    x_nxt = (x_q == H_MAX) ? 10'd0 : x_q + 10'd1;
    y_nxt = y_q;
    if (x_q == H_MAX) begin
      y_nxt = (y_q == V_MAX) ? 10'd0 : y_q + 10'd1;
    end else begin
      y_nxt = y_q;
    end
    hs_raw = !((x_nxt >= HS_START) && (x_nxt < HS_END));
    vs_raw = !((y_nxt >= VS_START) && (y_nxt < VS_END));

    x_d       = x_q;
    y_d       = y_q;
    blank_d   = blank_q;
    fc_d      = fc_q;
    fs_d      = 1'b0;
    hs_pipe_d = hs_pipe_q;
    vs_pipe_d = vs_pipe_q;

    if (pix_en) begin
      x_d          = x_nxt;
      y_d          = y_nxt;
      blank_d      = (x_nxt < H_VIS) && (y_nxt < V_VIS);
      hs_pipe_d[0] = hs_raw;
      vs_pipe_d[0] = vs_raw;
      for (int i = 1; i <= int'(SYNC_DELAY); i++) begin
        hs_pipe_d[i] = hs_pipe_q[i-1];
        vs_pipe_d[i] = vs_pipe_q[i-1];
      end
      if ((x_nxt == 10'd0) && (y_nxt == 10'd0)) begin
        fs_d = 1'b1;
        fc_d = fc_q + 8'd1;
      end else begin
        fs_d = 1'b0;
        fc_d = fc_q;
      end
    end else begin
      fs_d = 1'b0;
    end
  end

  // Reset parks the counters on the last pixel so the first enabled edge lands on (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q       <= H_MAX;
      y_q       <= V_MAX;
      blank_q   <= 1'b0;
      fs_q      <= 1'b0;
      fc_q      <= 8'd0;
      hs_pipe_q <= '1;
      vs_pipe_q <= '1;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      blank_q   <= blank_d;
      fs_q      <= fs_d;
      fc_q      <= fc_d;
      hs_pipe_q <= hs_pipe_d;
      vs_pipe_q <= vs_pipe_d;
    end
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign hs          = hs_pipe_q[SYNC_DELAY];
  assign vs          = vs_pipe_q[SYNC_DELAY];
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size timing for line-level behaviour, a reduced-size
// raster (15x13) for frame-level behaviour, sync alignment and counter wrap.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, rst_b, en_b;
  logic [9:0] xa, ya, xb, yb, xc, yc;
  logic blk_a, hs_a, vs_a, fs_a, blk_b, hs_b, vs_b, fs_b, blk_c, hs_c, vs_c, fs_c;
  logic [7:0] fc_a, fc_b, fc_c;

  vga_timing_gen #(.SYNC_DELAY(1)) dut_a (
    .vga_clk(clk), .reset_n(rst_a), .pix_en(en_a), .DrawX(xa), .DrawY(ya),
    .blank(blk_a), .hs(hs_a), .vs(vs_a), .frame_start(fs_a), .frame_count(fc_a));

  vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_DELAY(0)) dut_b (
    .vga_clk(clk), .reset_n(rst_b), .pix_en(en_b), .DrawX(xb), .DrawY(yb),
    .blank(blk_b), .hs(hs_b), .vs(vs_b), .frame_start(fs_b), .frame_count(fc_b));

  vga_timing_gen #(.H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                   .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_DELAY(1)) dut_c (
    .vga_clk(clk), .reset_n(rst_b), .pix_en(en_b), .DrawX(xc), .DrawY(yc),
    .blank(blk_c), .hs(hs_c), .vs(vs_c), .frame_start(fs_c), .frame_count(fc_c));

  typedef struct {
    int         n;
    logic [9:0] x;
    logic [9:0] y;
    logic       b, h, v, f;
    logic [7:0] c;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_a();
    return {xa, ya, blk_a, hs_a, vs_a, fs_a, fc_a};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tab[11];
    int ti, hs_low, first_low, fs_cnt, second_fs, vsb_low, vsc_low, fs_hi;

    tab[0]  = '{1,   10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1};
    tab[1]  = '{2,   10'd1,   10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1};
    tab[2]  = '{640, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1};
    tab[3]  = '{641, 10'd640, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
    tab[4]  = '{656, 10'd655, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
    tab[5]  = '{657, 10'd656, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
    tab[6]  = '{658, 10'd657, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    tab[7]  = '{753, 10'd752, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    tab[8]  = '{754, 10'd753, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
    tab[9]  = '{800, 10'd799, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
    tab[10] = '{801, 10'd0,   10'd1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1};

    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b1; en_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", pack_a(), {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0});
    chk("reset_b", {xb, yb, blk_b, hs_b, vs_b, fs_b, fc_b},
        {10'd14, 10'd12, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0});

    // One full line plus the wrap on the full-size raster.
    @(negedge clk) rst_a = 1'b1;
    ti = 0; hs_low = 0; first_low = -1;
    for (int n = 1; n <= 801; n++) begin
      @(posedge clk); #1;
      if (ti < 11 && tab[ti].n == n) begin
        chk($sformatf("line_vec_n%0d", n), pack_a(),
            {tab[ti].x, tab[ti].y, tab[ti].b, tab[ti].h, tab[ti].v, tab[ti].f, tab[ti].c});
        ti++;
      end
      if (!hs_a) begin
        hs_low++;
        if (first_low < 0) first_low = int'(xa);
      end
    end
    chk("table_all_applied", ti, 11);
    chk("hs_low_width", hs_low, 96);
    chk("hs_first_low_x", first_low, 657);

    // Asynchronous mid-frame reset at (300,1).
    repeat (300) @(posedge clk);
    #1;
    chk("pre_reset_pos", {xa, ya}, {10'd300, 10'd1});
    #2 rst_a = 1'b0;
    #1;
    chk("async_reset", pack_a(), {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0});
    @(negedge clk) rst_a = 1'b1;
    @(posedge clk); #1;
    chk("after_reset", pack_a(), {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1});
    en_a = 1'b0;
    @(posedge clk); #1;
    chk("fs_drop_en_low", {xa, fs_a, fc_a}, {10'd0, 1'b0, 8'd1});

    // 50% pix_en duty: one line takes 1600 clocks, hs low 192 clocks.
    hs_low = 0; fs_hi = 0;
    for (int k = 0; k < 1600; k++) begin
      en_a = (k % 2 == 0);
      @(posedge clk); #1;
      if (!hs_a) hs_low++;
      if (fs_a) fs_hi++;
      if (k == 799) chk("half_rate_x", xa, 10'd400);
    end
    chk("half_rate_wrap", {xa, ya}, {10'd0, 10'd1});
    chk("half_rate_hs_width", hs_low, 192);
    chk("half_rate_no_fs", fs_hi, 0);
    en_a = 1'b1;

    // Reduced raster: 195 enabled cycles per frame, 256 frames.
    @(negedge clk) rst_b = 1'b1;
    fs_cnt = 0; second_fs = 0; vsb_low = 0; vsc_low = 0;
    for (int n = 1; n <= 195 * 256; n++) begin
      @(posedge clk); #1;
      if (fs_b) begin
        fs_cnt++;
        if (n > 1 && second_fs == 0) second_fs = n;
      end
      if (n == 1) chk("small_first", {xb, yb, blk_b, fs_b, fc_b}, {10'd0, 10'd0, 1'b1, 1'b1, 8'd1});
      if (n <= 195) begin
        if (!vs_b) vsb_low++;
        if (!vs_c) vsc_low++;
        if (yb == 10'd0 && xb == 10'd9)  chk("d0_hs_x9",  hs_b, 1'b1);
        if (yb == 10'd0 && xb == 10'd10) chk("d0_hs_x10", hs_b, 1'b0);
        if (yb == 10'd0 && xb == 10'd12) chk("d0_hs_x12", hs_b, 1'b0);
        if (yb == 10'd0 && xb == 10'd13) chk("d0_hs_x13", hs_b, 1'b1);
        if (yb == 10'd7 && xb == 10'd14) chk("d0_vs_y7",  vs_b, 1'b1);
        if (yb == 10'd8 && xb == 10'd0)  chk("d0_vs_y8",  vs_b, 1'b0);
        if (yb == 10'd10 && xb == 10'd0) chk("d0_vs_y10", vs_b, 1'b1);
        if (yb == 10'd7 && xb == 10'd0)  chk("d0_blank_y7", blk_b, 1'b0);
        if (yc == 10'd8 && xc == 10'd0)  chk("d1_vs_8_0",  vs_c, 1'b1);
        if (yc == 10'd8 && xc == 10'd1)  chk("d1_vs_8_1",  vs_c, 1'b0);
        if (yc == 10'd10 && xc == 10'd0) chk("d1_vs_10_0", vs_c, 1'b0);
        if (yc == 10'd10 && xc == 10'd1) chk("d1_vs_10_1", vs_c, 1'b1);
      end
      if (n == 195 * 255)     chk("fc_255", fc_b, 8'd255);
      if (n == 195 * 255 + 1) chk("fc_wrap", {fs_b, fc_b}, {1'b1, 8'd0});
    end
    chk("second_fs_cycle", second_fs, 196);
    chk("fs_pulse_count", fs_cnt, 256);
    chk("d0_vs_width", vsb_low, 30);
    chk("d1_vs_width", vsc_low, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
